conv_window_scheduler: RTL and testbench

Controller that sequences memory_unit through kernel-window reads for convolution. It walks all valid output positions of an IMAGE_WIDTH x IMAGE_HEIGHT image in raster order and assigns up to NUM_UNITS positions per batch, one position per memory unit. For each batch it issues base addresses, then pulses `step` for the remaining kernel taps. It hands each completed batch to the downstream MAC stage over a valid/ready handshake.

---
 rtl/conv_window_scheduler_pkg.sv | 28 ++
 rtl/conv_window_scheduler_window_addr_gen.sv | 49 ++++
 rtl/conv_window_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_scheduler_pkg.sv
// Shared types for the convolution window scheduler: FSM state encoding,
// default geometry, word type and the per-unit address vector type.
package ttpu_sched_pkg;

    localparam int SCHED_DATA_WIDTH   = 16;
    localparam int SCHED_IMAGE_WIDTH  = 4;
    localparam int SCHED_IMAGE_HEIGHT = 4;
    localparam int SCHED_NUM_UNITS    = 2;
    localparam int SCHED_ADDR_W       = $clog2(SCHED_IMAGE_WIDTH * SCHED_IMAGE_HEIGHT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        STEP  = 3'd2,
        WAIT  = 3'd3,
        HAND  = 3'd4,
        DONE  = 3'd5
    } sched_state_t;

    typedef logic [SCHED_DATA_WIDTH-1:0] sched_data_t;
    typedef logic [SCHED_NUM_UNITS-1:0][SCHED_ADDR_W-1:0] sched_addr_vec_t;

    // Address width needed to index every pixel of a w x h image.
    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/conv_window_scheduler_window_addr_gen.sv
// window_addr_gen: maps a batch origin p0 and kernel side K to the window
// base address of every lane, the lane-valid mask and the final-batch flag.
// Purely combinational.
module window_addr_gen
    import ttpu_sched_pkg::*;
#(
    parameter  int IMAGE_WIDTH  = 4,
    parameter  int IMAGE_HEIGHT = 4,
    parameter  int NUM_UNITS    = 2,
    localparam int AW           = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int KW           = $clog2(IMAGE_WIDTH),
    localparam int PW           = AW + 1
) (
    input  logic [PW-1:0]                 i_p0,
    input  logic [KW-1:0]                 i_k,
    output logic [NUM_UNITS-1:0][AW-1:0]  o_base,
    output logic [NUM_UNITS-1:0]          o_mask,
    output logic                          o_last
);

    // Lane u covers output position p0+u; its row/column in the output grid
    // selects the top-left pixel of its window. Out-of-range lanes read 0.
    always_comb begin
        int v_out_w;
        int v_out_h;
        int v_total;
        int v_pos;
        // An out-of-range K only reaches here while idle; clamp so the
        // divider never sees zero.
        v_out_w = (IMAGE_WIDTH  >= int'(i_k)) ? (IMAGE_WIDTH  - int'(i_k) + 1) : 1;
        v_out_h = (IMAGE_HEIGHT >= int'(i_k)) ? (IMAGE_HEIGHT - int'(i_k) + 1) : 1;
        v_total = v_out_w * v_out_h;
        v_pos   = 0;
        o_base  = {(NUM_UNITS * AW){1'b0}};
        o_mask  = {NUM_UNITS{1'b0}};
        o_last  = ((int'(i_p0) + NUM_UNITS) >= v_total);
        for (int u = 0; u < NUM_UNITS; u++) begin
            v_pos = int'(i_p0) + u;
            if (v_pos < v_total) begin
                o_mask[u] = 1'b1;
                o_base[u] = AW'((v_pos / v_out_w) * IMAGE_WIDTH + (v_pos % v_out_w));
            end else begin
                o_mask[u] = 1'b0;
                o_base[u] = {AW{1'b0}};
            end
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks every valid output position of the image in
// raster order, NUM_UNITS positions per batch, driving memory_unit through
// ISSUE (base addresses) and STEP (remaining K*K-1 taps), then offers each
// finished batch downstream over win_valid/win_ready.
// Optional build macro TTPU_SCHED_PERF_EN adds perf_cycles/perf_stalls.
module conv_window_scheduler
    import ttpu_sched_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int IMAGE_WIDTH  = 4,
    parameter  int IMAGE_HEIGHT = 4,
    parameter  int NUM_UNITS    = 2,
    localparam int AW           = addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
    localparam int KW           = $clog2(IMAGE_WIDTH),
    localparam int PW           = AW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [KW-1:0]                 kernel_dim,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic                          mem_en,
    output logic                          mem_read,
    output logic                          mem_write,
    output logic                          mem_step,
    output logic [NUM_UNITS-1:0][AW-1:0]  mem_addres,
    input  logic                          mem_en_out,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [NUM_UNITS-1:0]          win_mask,
    output logic                          win_last,
    output logic [AW-1:0]                 win_base
`ifdef TTPU_SCHED_PERF_EN
    ,
    output logic [31:0]                   perf_cycles,
    output logic [31:0]                   perf_stalls
`endif
);

    localparam int K_MAX = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;

    sched_state_t                  r_state;
    logic [KW-1:0]                 r_k;
    logic [PW-1:0]                 r_p0;
    logic [PW-1:0]                 r_tap;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_cfg_err;
    logic                          r_mem_en;
    logic                          r_mem_step;
    logic [NUM_UNITS-1:0][AW-1:0]  r_mem_addres;
    logic                          r_win_valid;
    logic [NUM_UNITS-1:0]          r_win_mask;
    logic                          r_win_last;
    logic [AW-1:0]                 r_win_base;

    logic [PW-1:0]                 w_gen_p0;
    logic [KW-1:0]                 w_gen_k;
    logic [NUM_UNITS-1:0][AW-1:0]  w_gen_base;
    logic [NUM_UNITS-1:0]          w_gen_mask;
    logic                          w_gen_last;
    logic                          w_k_legal;
    logic [PW-1:0]                 w_tap_end;
    logic [DATA_WIDTH-1:0]         w_unused_word;

    // The word width only shapes the shared word type; tie it off here.
    assign w_unused_word = {DATA_WIDTH{1'b0}};

    assign w_k_legal = (int'(kernel_dim) >= 1) && (int'(kernel_dim) <= K_MAX);
    assign w_tap_end = PW'(int'(r_k) * int'(r_k) - 2);

    // Feed the address generator with the origin the next ISSUE will use, so
    // the base registers can be loaded on the same edge that enters ISSUE.
    always_comb begin
        w_gen_p0 = r_p0;
        w_gen_k  = r_k;
        case (r_state)
            IDLE: begin
                w_gen_p0 = {PW{1'b0}};
                w_gen_k  = kernel_dim;
            end
            HAND: begin
                w_gen_p0 = r_p0 + PW'(NUM_UNITS);
                w_gen_k  = r_k;
            end
            default: begin
                w_gen_p0 = r_p0;
                w_gen_k  = r_k;
            end
        endcase
    end

    window_addr_gen #(
        .IMAGE_WIDTH  (IMAGE_WIDTH),
        .IMAGE_HEIGHT (IMAGE_HEIGHT),
        .NUM_UNITS    (NUM_UNITS)
    ) u_addr_gen (
        .i_p0   (w_gen_p0),
        .i_k    (w_gen_k),
        .o_base (w_gen_base),
        .o_mask (w_gen_mask),
        .o_last (w_gen_last)
    );

    // Scheduler FSM; every output is a register loaded on the edge that
    // enters the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_k          <= {KW{1'b0}};
            r_p0         <= {PW{1'b0}};
            r_tap        <= {PW{1'b0}};
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_step   <= 1'b0;
            r_mem_addres <= {(NUM_UNITS * AW){1'b0}};
            r_win_valid  <= 1'b0;
            r_win_mask   <= {NUM_UNITS{1'b0}};
            r_win_last   <= 1'b0;
            r_win_base   <= {AW{1'b0}};
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_k_legal) begin
                        r_k          <= kernel_dim;
                        r_p0         <= w_gen_p0;
                        r_tap        <= {PW{1'b0}};
                        r_busy       <= 1'b1;
                        r_mem_en     <= 1'b1;
                        r_mem_step   <= 1'b0;
                        r_mem_addres <= w_gen_base;
                        r_win_mask   <= w_gen_mask;
                        r_win_last   <= w_gen_last;
                        r_win_base   <= w_gen_base[0];
                        r_state      <= ISSUE;
                    end else if (start) begin
                        r_cfg_err <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_tap <= {PW{1'b0}};
                    if (int'(r_k) > 1) begin
                        r_mem_step <= 1'b1;
                        r_state    <= STEP;
                    end else begin
                        r_mem_step <= 1'b0;
                        r_state    <= WAIT;
                    end
                end
                STEP: begin
                    if (r_tap == w_tap_end) begin
                        r_mem_step <= 1'b0;
                        r_state    <= WAIT;
                    end else begin
                        r_tap <= r_tap + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                WAIT: begin
                    if (mem_en_out) begin
                        r_mem_en    <= 1'b0;
                        r_win_valid <= 1'b1;
                        r_state     <= HAND;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                HAND: begin
                    if (win_ready && r_win_last) begin
                        r_win_valid <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end else if (win_ready) begin
                        r_win_valid  <= 1'b0;
                        r_p0         <= w_gen_p0;
                        r_mem_en     <= 1'b1;
                        r_mem_addres <= w_gen_base;
                        r_win_mask   <= w_gen_mask;
                        r_win_last   <= w_gen_last;
                        r_win_base   <= w_gen_base[0];
                        r_state      <= ISSUE;
                    end else begin
                        r_state <= HAND;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_step  <= 1'b0;
                    r_win_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign cfg_err    = r_cfg_err;
    assign mem_en     = r_mem_en;
    assign mem_read   = r_mem_en;
    assign mem_write  = 1'b0;
    assign mem_step   = r_mem_step;
    assign mem_addres = r_mem_addres;
    assign win_valid  = r_win_valid;
    assign win_mask   = r_win_mask;
    assign win_last   = r_win_last;
    assign win_base   = r_win_base;

`ifdef TTPU_SCHED_PERF_EN
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stalls;

    // Pass statistics: busy cycles, and cycles lost waiting on memory or on
    // downstream backpressure. Cleared by an accepted start, held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else if ((r_state == IDLE) && start && w_k_legal) begin
            r_perf_cycles <= 32'd0;
            r_perf_stalls <= 32'd0;
        end else begin
            if (r_busy) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end else begin
                r_perf_cycles <= r_perf_cycles;
            end
            if ((r_state == WAIT) || ((r_state == HAND) && !win_ready)) begin
                r_perf_stalls <= r_perf_stalls + 32'd1;
            end else begin
                r_perf_stalls <= r_perf_stalls;
            end
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench for conv_window_scheduler (default 4x4, 2 units).
// A reference model enumerates output positions row by row and chunks them
// into batches; observed handshakes are compared against it.
module tb_conv_window_scheduler;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int NU = 2;
    localparam int AW = 4;
    localparam int KW = 2;

    typedef struct packed {
        logic [NU-1:0][AW-1:0] addr;
        logic [NU-1:0]         mask;
        logic                  last;
        logic [AW-1:0]         base;
    } win_t;

    logic                  clk = 1'b0;
    logic                  reset, start, mem_en_out, win_ready;
    logic [KW-1:0]         kernel_dim;
    logic                  busy, done, cfg_err, mem_en, mem_read, mem_write, mem_step;
    logic                  win_valid, win_last;
    logic [NU-1:0][AW-1:0] mem_addres;
    logic [NU-1:0]         win_mask;
    logic [AW-1:0]         win_base;
`ifdef TTPU_SCHED_PERF_EN
    logic [31:0]           perf_cycles, perf_stalls;
`endif

    always #5 clk = ~clk;

    conv_window_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .kernel_dim(kernel_dim),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
        .mem_step(mem_step), .mem_addres(mem_addres), .mem_en_out(mem_en_out),
        .win_valid(win_valid), .win_ready(win_ready), .win_mask(win_mask),
        .win_last(win_last), .win_base(win_base)
`ifdef TTPU_SCHED_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;

    win_t exp_q[$];
    win_t obs_q[$];
    int   obs_steps[$];
    int   obs_busy, obs_done, obs_cfg, obs_unstable, obs_wr, obs_hand_stall;
    bit   obs_timeout;

    // Reference: list every output position's base pixel in raster order,
    // then group consecutive entries into batches of NU lanes.
    task automatic build_model(input int k);
        int bases[$];
        win_t w;
        exp_q.delete();
        for (int r = 0; r <= H - k; r++)
            for (int c = 0; c <= W - k; c++)
                bases.push_back(r * W + c);
        for (int i = 0; i < bases.size(); i += NU) begin
            w = '0;
            for (int u = 0; u < NU; u++) begin
                if (i + u < bases.size()) begin
                    w.addr[u] = AW'(bases[i + u]);
                    w.mask[u] = 1'b1;
                end
            end
            w.base = w.addr[0];
            w.last = (i + NU >= bases.size());
            exp_q.push_back(w);
        end
    endtask

    // Drive one pass: memory answers 'delay' cycles after the last tap,
    // downstream readiness is random with optional forced hold on one batch.
    task automatic run_pass(input int k, input int delay, input int ready_pct,
                            input int hold_batch, input int hold_cycles);
        bit   prev_en = 0, prev_valid = 0, prev_ready = 0, armed = 0, fin = 0;
        int   mcnt = 0, steps = 0, held = 0, hand_idx = 0, tail = 0;
        win_t prev_w = '0, cur;
        logic [NU-1:0][AW-1:0] cur_addr = '0;
        obs_q.delete(); obs_steps.delete();
        obs_busy = 0; obs_done = 0; obs_cfg = 0; obs_unstable = 0;
        obs_wr = 0; obs_hand_stall = 0; obs_timeout = 0;
        kernel_dim = KW'(k);
        start = 1'b1;
        for (int cyc = 0; cyc < 800 && tail < 2; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            kernel_dim = KW'($urandom);
            cur = '{addr: mem_addres, mask: win_mask, last: win_last, base: win_base};
            if (busy) obs_busy++;
            if (done) obs_done++;
            if (cfg_err) obs_cfg++;
            if (mem_write || (mem_read !== mem_en)) obs_wr++;
            if (prev_valid && !prev_ready && (!win_valid || cur !== prev_w)) obs_unstable++;
            if (mem_en && !prev_en) begin
                steps = 0; cur_addr = mem_addres; mcnt = k * k - 1 + delay; armed = 1;
            end else begin
                if (mem_step) steps++;
                if (armed) mcnt--;
            end
            if ((mem_en || win_valid) && mem_addres !== cur_addr) obs_unstable++;
            mem_en_out = armed && (mcnt == 0);
            if (mem_en_out) armed = 0;
            if (win_valid) begin
                if (hand_idx == hold_batch && held < hold_cycles) begin
                    win_ready = 1'b0; held++;
                end else begin
                    win_ready = ($urandom_range(99) < ready_pct);
                end
                if (win_ready) begin
                    obs_q.push_back(cur); obs_steps.push_back(steps); hand_idx++;
                end else begin
                    obs_hand_stall++;
                end
            end else begin
                win_ready = 1'($urandom_range(1));
            end
            prev_en = mem_en; prev_valid = win_valid; prev_ready = win_ready; prev_w = cur;
            if (done) fin = 1;
            if (fin) tail++;
        end
        if (!fin) obs_timeout = 1;
        win_ready = 1'b0; mem_en_out = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if ({busy, done, cfg_err, mem_en, mem_read, mem_write, mem_step, win_valid, win_last} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl got %b expected 000000000",
                     {busy, done, cfg_err, mem_en, mem_read, mem_write, mem_step, win_valid, win_last});
        end
        n_total++;
        if ({mem_addres, win_mask, win_base} !== '0) begin
            n_bad++; $display("FAIL reset_data got %h expected 0", {mem_addres, win_mask, win_base});
        end
    endtask

    task automatic test_k2();
        build_model(2);
        run_pass(2, 1, 100, -1, 0);
        n_total++;
        if (obs_timeout || obs_q.size() != exp_q.size()) begin
            n_bad++; $display("FAIL k2_batches got %0d (timeout %0d) expected %0d", obs_q.size(), obs_timeout, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_steps[i] != 3) begin
                n_bad++; $display("FAIL k2_batch%0d got %h steps %0d expected %h steps 3", i, obs_q[i], obs_steps[i], exp_q[i]);
            end
        end
        n_total++;
        if (obs_done != 1 || obs_cfg != 0 || obs_unstable != 0 || obs_wr != 0) begin
            n_bad++; $display("FAIL k2_flags got done=%0d cfg=%0d unstable=%0d wr=%0d expected 1 0 0 0", obs_done, obs_cfg, obs_unstable, obs_wr);
        end
        n_total++;
        if (obs_busy != 5 * (4 + 1 + 1) + 1) begin
            n_bad++; $display("FAIL k2_busy got %0d expected %0d", obs_busy, 5 * 6 + 1);
        end
    endtask

    task automatic test_k1();
        build_model(1);
        run_pass(1, 1, 100, -1, 0);
        n_total++;
        if (obs_timeout || obs_q.size() != 8 || exp_q.size() != 8) begin
            n_bad++; $display("FAIL k1_batches got %0d (timeout %0d) expected 8", obs_q.size(), obs_timeout);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_steps[i] != 0) begin
                n_bad++; $display("FAIL k1_batch%0d got %h steps %0d expected %h steps 0", i, obs_q[i], obs_steps[i], exp_q[i]);
            end
        end
        n_total++;
        if (obs_busy != 8 * 3 + 1 || obs_done != 1) begin
            n_bad++; $display("FAIL k1_busy got %0d done %0d expected 25 done 1", obs_busy, obs_done);
        end
    endtask

    task automatic test_cfg_err();
        kernel_dim = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_total++;
        if ({cfg_err, busy, mem_en} !== 3'b100) begin
            n_bad++; $display("FAIL cfg_err_pulse got %b expected 100", {cfg_err, busy, mem_en});
        end
        @(negedge clk);
        n_total++;
        if ({cfg_err, busy, mem_en} !== 3'b000) begin
            n_bad++; $display("FAIL cfg_err_clear got %b expected 000", {cfg_err, busy, mem_en});
        end
    endtask

    task automatic test_backpressure();
        build_model(2);
        run_pass(2, 1, 100, 1, 4);
        n_total++;
        if (obs_timeout || obs_q.size() != exp_q.size() || obs_hand_stall != 4 || obs_unstable != 0) begin
            n_bad++; $display("FAIL bp_summary got n=%0d stall=%0d unstable=%0d expected n=%0d stall=4 unstable=0",
                              obs_q.size(), obs_hand_stall, obs_unstable, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                n_bad++; $display("FAIL bp_batch%0d got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_total++;
        if (obs_busy != 5 * 6 + 1 + 4) begin
            n_bad++; $display("FAIL bp_busy got %0d expected 35", obs_busy);
        end
    endtask

    task automatic test_reset_midpass();
        bit seen = 0;
        win_ready = 1'b1; kernel_dim = 2'd2; start = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            seen = mem_step;
        end
        n_total++;
        if (!seen) begin
            n_bad++; $display("FAIL rst_mid_step got no mem_step expected one within 20 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_total++;
        if ({busy, done, mem_en, mem_step, win_valid, mem_addres, win_mask, win_base} !== '0) begin
            n_bad++; $display("FAIL rst_mid_outputs got %h expected 0",
                              {busy, done, mem_en, mem_step, win_valid, mem_addres, win_mask, win_base});
        end
        repeat (3) begin
            @(negedge clk);
            n_total++;
            if ({done, busy} !== 2'b00) begin
                n_bad++; $display("FAIL rst_mid_idle got %b expected 00", {done, busy});
            end
        end
        build_model(3);
        run_pass(3, 1, 100, -1, 0);
        n_total++;
        if (obs_timeout || obs_q.size() != 2 || exp_q.size() != 2) begin
            n_bad++; $display("FAIL k3_batches got %0d expected 2", obs_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_total++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_steps[i] != 8) begin
                n_bad++; $display("FAIL k3_batch%0d got %h steps %0d expected %h steps 8", i, obs_q[i], obs_steps[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int k, d, pct;
            k = $urandom_range(3, 1); d = $urandom_range(4, 1); pct = $urandom_range(100, 30);
            build_model(k);
            run_pass(k, d, pct, -1, 0);
            n_total++;
            if (obs_timeout || obs_q.size() != exp_q.size() || obs_done != 1 || obs_unstable != 0) begin
                n_bad++; $display("FAIL rnd%0d_summary k=%0d got n=%0d done=%0d unstable=%0d expected n=%0d done=1 unstable=0",
                                  it, k, obs_q.size(), obs_done, obs_unstable, exp_q.size());
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_total++;
                if (i >= obs_q.size() || obs_q[i] !== exp_q[i] || obs_steps[i] != k * k - 1) begin
                    n_bad++; $display("FAIL rnd%0d_batch%0d got %h steps %0d expected %h steps %0d",
                                      it, i, obs_q[i], obs_steps[i], exp_q[i], k * k - 1);
                end
            end
        end
    endtask

`ifdef TTPU_SCHED_PERF_EN
    task automatic test_perf();
        build_model(2);
        run_pass(2, 2, 100, -1, 0);
        n_total++;
        if (perf_stalls !== 32'd10) begin
            n_bad++; $display("FAIL perf_stalls got %0d expected 10", perf_stalls);
        end
        n_total++;
        if (perf_cycles !== 32'(obs_busy) || obs_busy != 5 * 7 + 1) begin
            n_bad++; $display("FAIL perf_cycles got %0d busy %0d expected %0d", perf_cycles, obs_busy, 5 * 7 + 1);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; kernel_dim = 2'd0; mem_en_out = 1'b0; win_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_k2();
        test_k1();
        test_cfg_err();
        test_backpressure();
        test_reset_midpass();
        test_random();
`ifdef TTPU_SCHED_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
